// File: rtl/parking_lane_if.sv
// Lane-controller bus: requests and pass pulse in, gate command and lot status out.
interface parking_lane_if #(
  parameter int unsigned CNT_W = 5
);
  logic             entry_req;
  logic             exit_req;
  logic             pass;
  logic             gate_open;
  logic             dir_in;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             timeout_err;
  logic             spurious_err;

  modport master (
    output entry_req, exit_req, pass,
    input  gate_open, dir_in, count, full, empty, timeout_err, spurious_err
  );

  modport slave (
    input  entry_req, exit_req, pass,
    output gate_open, dir_in, count, full, empty, timeout_err, spurious_err
  );
endinterface

// File: rtl/parking_lane_ctrl.sv
// Shared bidirectional lane controller: arbitrates entry/exit, drives the barrier,
// tracks lot occupancy and flags timeout / spurious-pass events.
module parking_lane_ctrl #(
  parameter int unsigned CAPACITY = 16,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned TIMEOUT  = 200,
  parameter int unsigned HOLDOFF  = 8,
  parameter int unsigned TMR_W    = 8
) (
  input logic          clk,
  input logic          reset_n,
  parking_lane_if.slave bus
);

  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2,
    HOLD     = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_in_q, last_in_d;
  logic             gate_open_q, gate_open_d;
  logic             dir_in_q, dir_in_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             timeout_q, timeout_d;
  logic             spurious_q, spurious_d;

  logic entry_ok_c;
  logic exit_ok_c;

  assign entry_ok_c = bus.entry_req & ~full_q;
  assign exit_ok_c  = bus.exit_req & ~empty_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      count_q     <= '0;
      last_in_q   <= 1'b0;
      gate_open_q <= 1'b0;
      dir_in_q    <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      timeout_q   <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      last_in_q   <= last_in_d;
      gate_open_q <= gate_open_d;
      dir_in_q    <= dir_in_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      timeout_q   <= timeout_d;
      spurious_q  <= spurious_d;
    end
  end

  // Next-state, timer and occupancy update; status flags follow the next count.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    count_d    = count_q;
    last_in_d  = last_in_q;
    timeout_d  = 1'b0;
    spurious_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        spurious_d = bus.pass;
        // Tie goes to the direction not served last.
        if (entry_ok_c && (!exit_ok_c || !last_in_q)) begin
          state_d   = OPEN_IN;
          timer_d   = '0;
          last_in_d = 1'b1;
        end else if (exit_ok_c) begin
          state_d   = OPEN_OUT;
          timer_d   = '0;
          last_in_d = 1'b0;
        end
      end
      OPEN_IN, OPEN_OUT: begin
        if (bus.pass) begin
          count_d = (state_q == OPEN_IN) ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
          state_d = HOLD;
          timer_d = '0;
        end else if (timer_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = HOLD;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      HOLD: begin
        spurious_d = bus.pass;
        if (timer_q == HOLD_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    gate_open_d = (state_d == OPEN_IN) || (state_d == OPEN_OUT);
    dir_in_d    = (state_d == OPEN_IN);
    full_d      = (count_d == CNT_MAX);
    empty_d     = (count_d == '0);
  end

  assign bus.gate_open    = gate_open_q;
  assign bus.dir_in       = dir_in_q;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.timeout_err  = timeout_q;
  assign bus.spurious_err = spurious_q;

endmodule

// File: tb/tb_parking_lane_ctrl.sv
// Directed bench for parking_lane_ctrl: arbitration, counting, timeout, spurious pass, reset.
module tb_parking_lane_ctrl;

  localparam int unsigned CNT_W   = 5;
  localparam int unsigned HOLDOFF = 8;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  parking_lane_if #(.CNT_W(CNT_W)) bus ();

  parking_lane_ctrl #(
    .CAPACITY(16), .CNT_W(CNT_W), .TIMEOUT(200), .HOLDOFF(HOLDOFF), .TMR_W(8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full served car in the requested direction, ending back in IDLE.
  task automatic serve(input logic is_entry, input int exp_cnt);
    if (is_entry) bus.entry_req = 1'b1;
    else          bus.exit_req  = 1'b1;
    step(1);
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    chk("serve_gate_open", 32'(bus.gate_open), 32'd1);
    chk("serve_dir", 32'(bus.dir_in), 32'(is_entry));
    bus.pass = 1'b1;
    step(1);
    bus.pass = 1'b0;
    chk("serve_gate_closed", 32'(bus.gate_open), 32'd0);
    chk("serve_count", 32'(bus.count), 32'(exp_cnt));
    chk("serve_full", 32'(bus.full), 32'(exp_cnt == 16));
    chk("serve_empty", 32'(bus.empty), 32'(exp_cnt == 0));
    step(HOLDOFF);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset_n       = 1'b0;
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    bus.pass      = 1'b0;
    step(2);
    chk("rst_gate", 32'(bus.gate_open), 32'd0);
    chk("rst_dir", 32'(bus.dir_in), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_tmo", 32'(bus.timeout_err), 32'd0);
    chk("rst_spur", 32'(bus.spurious_err), 32'd0);
    reset_n = 1'b1;
    step(1);

    // First entry: 1-cycle grant latency, pass 5 cycles later, 8-cycle hold
    bus.entry_req = 1'b1;
    step(1);
    bus.entry_req = 1'b0;
    chk("t1_gate", 32'(bus.gate_open), 32'd1);
    chk("t1_dir", 32'(bus.dir_in), 32'd1);
    step(4);
    chk("t1_still_open", 32'(bus.gate_open), 32'd1);
    bus.pass = 1'b1;
    step(1);
    bus.pass = 1'b0;
    chk("t1_closed", 32'(bus.gate_open), 32'd0);
    chk("t1_count", 32'(bus.count), 32'd1);
    chk("t1_empty", 32'(bus.empty), 32'd0);
    chk("t1_tmo", 32'(bus.timeout_err), 32'd0);
    bus.entry_req = 1'b1;
    step(HOLDOFF);
    chk("t1_hold_ignores_req", 32'(bus.gate_open), 32'd0);
    step(1);
    chk("t1_regrant", 32'(bus.gate_open), 32'd1);
    bus.entry_req = 1'b0;
    bus.pass = 1'b1;
    step(1);
    bus.pass = 1'b0;
    chk("t1_count2", 32'(bus.count), 32'd2);
    step(HOLDOFF);

    // Fill to capacity, then entry must be refused
    for (int i = 3; i <= 16; i++) serve(1'b1, i);
    chk("t2_full", 32'(bus.full), 32'd1);
    bus.entry_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("t2_no_grant_full", 32'(bus.gate_open), 32'd0);
    end
    bus.entry_req = 1'b0;
    serve(1'b0, 15);

    // Alternating fairness from count=3 with last-served = exit
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) serve(1'b1, i);
    serve(1'b0, 3);
    bus.entry_req = 1'b1;
    bus.exit_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("t3_gate", 32'(bus.gate_open), 32'd1);
      chk("t3_dir", 32'(bus.dir_in), 32'((k % 2) == 0));
      bus.pass = 1'b1;
      step(1);
      bus.pass = 1'b0;
      chk("t3_count", 32'(bus.count), ((k % 2) == 0) ? 32'd4 : 32'd3);
      if (k == 3) begin
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
      end
      step(HOLDOFF);
    end

    // Timeout without pass, then pass on the last open cycle
    bus.entry_req = 1'b1;
    step(1);
    bus.entry_req = 1'b0;
    chk("t4_open", 32'(bus.gate_open), 32'd1);
    step(199);
    chk("t4_open_199", 32'(bus.gate_open), 32'd1);
    step(1);
    chk("t4_closed", 32'(bus.gate_open), 32'd0);
    chk("t4_tmo", 32'(bus.timeout_err), 32'd1);
    chk("t4_count", 32'(bus.count), 32'd3);
    step(1);
    chk("t4_tmo_pulse", 32'(bus.timeout_err), 32'd0);
    step(HOLDOFF - 1);
    bus.entry_req = 1'b1;
    step(1);
    bus.entry_req = 1'b0;
    chk("t4b_open", 32'(bus.gate_open), 32'd1);
    step(199);
    bus.pass = 1'b1;
    step(1);
    bus.pass = 1'b0;
    chk("t4b_closed", 32'(bus.gate_open), 32'd0);
    chk("t4b_no_tmo", 32'(bus.timeout_err), 32'd0);
    chk("t4b_count", 32'(bus.count), 32'd4);
    step(1);
    chk("t4b_no_tmo_late", 32'(bus.timeout_err), 32'd0);
    step(HOLDOFF - 1);

    // Spurious pass in IDLE, then a held pass that spills into HOLD
    bus.pass = 1'b1;
    step(1);
    bus.pass = 1'b0;
    chk("t5_spur_idle", 32'(bus.spurious_err), 32'd1);
    chk("t5_count_idle", 32'(bus.count), 32'd4);
    step(1);
    chk("t5_spur_pulse", 32'(bus.spurious_err), 32'd0);
    bus.entry_req = 1'b1;
    step(1);
    bus.entry_req = 1'b0;
    bus.pass = 1'b1;
    step(1);
    chk("t5_count_once", 32'(bus.count), 32'd5);
    chk("t5_spur_first", 32'(bus.spurious_err), 32'd0);
    step(1);
    bus.pass = 1'b0;
    chk("t5_spur_hold", 32'(bus.spurious_err), 32'd1);
    chk("t5_count_hold", 32'(bus.count), 32'd5);
    step(HOLDOFF - 1);

    // Exit refused when empty
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    bus.exit_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("t6_no_exit_empty", 32'(bus.gate_open), 32'd0);
    end
    bus.exit_req = 1'b0;

    // Asynchronous reset mid OPEN_IN with count=7
    for (int i = 1; i <= 7; i++) serve(1'b1, i);
    bus.entry_req = 1'b1;
    step(1);
    bus.entry_req = 1'b0;
    chk("t7_open", 32'(bus.gate_open), 32'd1);
    chk("t7_count", 32'(bus.count), 32'd7);
    #1 reset_n = 1'b0;
    #1;
    chk("t7_async_gate", 32'(bus.gate_open), 32'd0);
    chk("t7_async_count", 32'(bus.count), 32'd0);
    chk("t7_async_empty", 32'(bus.empty), 32'd1);
    chk("t7_async_dir", 32'(bus.dir_in), 32'd0);
    step(1);
    reset_n = 1'b1;
    step(1);
    chk("t7_post_idle", 32'(bus.gate_open), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
